rda_addsub_pipe: RTL and testbench
==================================

// Module: rda_addsub_pipe
// PURPOSE
//   Parametrised, pipelined recursive-doubling (KPG prefix) adder/subtractor.
//   Generalises the fixed 32-bit RDA datapath: WIDTH and registers-per-prefix-level are set
//   by parameters, and the block adds a subtract mode, carry-in, carry-out, signed overflow
//   and valid/ready flow control.
//   Sits between operand producers and the ALU result bus in the pipelined datapath.
// PARAMETERS
//   WIDTH  32  operand/sum width in bits, >= 4
//   LPS     2  prefix levels per register segment, 1..L (L = $clog2(WIDTH+1))
//   Derived: NSEG = ceil(L/LPS); LAT = NSEG + 2 cycles, accept to out_valid.
//   WIDTH=32,LPS=2 gives L=6, NSEG=3, LAT=5.
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      block accepts beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in, used only when sub=0
//   sub        in   1      1: A-B (B inverted, carry-in forced 1); 0: A+B+cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer takes result this cycle
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB ^ cout
// BEHAVIOUR
//   - Reset (rst=0, any time, async): all stage valid bits and data regs cleared.
//     out_valid=0, sum=0, cout=0, ovf=0.
//     In-flight beats are discarded. in_ready=1 from first cycle after release.
//   - Global stall: adv = !out_valid | out_ready; in_ready = adv.
//     Accept when in_valid & in_ready.
//   - All stages (input reg, NSEG prefix regs, output reg) load only when adv=1.
//     Each stage's valid bit loads its predecessor's valid bit (bubbles propagate).
//     Input stage valid loads in_valid.
//   - When adv=0, every register holds; sum/cout/ovf/out_valid are stable until taken.
//   - Stage 0 registers A, B^{WIDTH{sub}}, c0 = sub | cin.
//   - KPG per bit i (positions 1..WIDTH): K if a=b=0, G if a=b=1, else P.
//     Position 0 = G if c0 else K. Encoding 2 bits: K=00, P=01, G=10.
//   - Prefix: Kogge-Stone doubling over WIDTH+1 positions, L levels.
//     Combine(hi,lo) = lo if hi==P else hi. Register after levels LPS, 2*LPS, ..., and after level L.
//   - Final stage: carry into bit i = (y[i]==G).
//     sum[i] = a'[i]^b'[i]^carry_i; cout = (y[WIDTH]==G); ovf = carry_{WIDTH-1} ^ cout.
//     Registered into output stage.
//   - Operand/propagate copies travel alongside prefix vectors through every segment.
//   - Throughput one beat/cycle with out_ready=1. Strict in-order, no drop, no duplicate.
//   - Simultaneous: in_valid & out_ready with full pipe: output retires and new beat enters
//     in the same edge.
//   - Arithmetic modulo 2^WIDTH. No saturation.
// STRUCTURE
//   - Package rda_pkg holds:
//     - typedef logic [1:0] kpg_t and localparams KPG_K/KPG_P/KPG_G;
//     - function kpg_combine(hi, lo).
//   - Sub-module rda_prefix_seg (params WIDTH, FIRST_LVL, NLVL) implements one
//     combinational level group. It is instantiated NSEG times via generate.
//     The top module owns all registers and handshake.
// TESTING
//   1. Reset mid-stream with 3 beats in flight -> out_valid=0, sum=0 immediately.
//      After release no stale beat appears and in_ready=1.
//   2. Add: a=32'hFFFFFFFF, b=1, cin=0, sub=0 -> after 5 cycles sum=0, cout=1, ovf=0.
//      Also a=32'h7FFFFFFF, b=1 -> sum=32'h80000000, ovf=1.
//   3. Subtract: a=5, b=7, sub=1 -> sum=32'hFFFFFFFE, cout=0, ovf=0.
//      Also a=32'h80000000, b=1, sub=1 -> sum=32'h7FFFFFFF, cout=1, ovf=1.
//   4. 1000 random beats, in_valid=1, out_ready=1 -> one result per cycle in order,
//      all match reference model.
//   5. Full pipe with out_ready=0 for 4 cycles -> in_ready=0, outputs frozen.
//      After release every beat arrives exactly once in order.
//      Random in_valid/out_ready toggling (50%) is scoreboard clean.
//   6. WIDTH=8, LPS=1 (L=4, LAT=6): 8'h7F+8'h01 -> 8'h80, ovf=1.
//      8'h00-8'h01 -> 8'hFF, cout=0.

Source files
------------

// File: rtl/rda_pkg.sv
// Shared types and helpers for the recursive-doubling (KPG prefix) adder/subtractor.
// Each carry-status digit is 2 bits: {generate, propagate}.
package rda_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b01;
    localparam kpg_t KPG_G = 2'b10;

    // A propagating upper span passes the lower span's status through; otherwise it dominates.
    function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
        return (hi == KPG_P) ? lo : hi;
    endfunction

    // Number of doubling levels needed to resolve WIDTH+1 positions.
    function automatic int rda_levels(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int rda_nseg(input int width, input int lps);
        return (rda_levels(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/rda_prefix_seg.sv
// One combinational group of Kogge-Stone doubling levels over WIDTH+1 KPG positions.
// Level FIRST_LVL+l combines each position with the one 2**(FIRST_LVL+l) below it.
module rda_prefix_seg
    import rda_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIRST_LVL = 0,
    parameter int NLVL      = 2
) (
    input  kpg_t [WIDTH:0] y_in,
    output kpg_t [WIDTH:0] y_out
);

    kpg_t [WIDTH:0] acc;
    kpg_t [WIDTH:0] prev;

    // Positions below the doubling distance already span back to position 0 and pass through.
    always_comb begin
        acc  = y_in;
        prev = y_in;
        for (int l = 0; l < NLVL; l++) begin
            prev = acc;
            for (int p = (1 << (FIRST_LVL + l)); p < WIDTH + 1; p++) begin
                acc[p] = kpg_combine(prev[p], prev[p - (1 << (FIRST_LVL + l))]);
            end
        end
    end

    assign y_out = acc;

endmodule

// File: rtl/rda_addsub_pipe.sv
// Pipelined recursive-doubling adder/subtractor with a global valid/ready stall.
// Stages: operand register, one register per prefix segment, result register.
module rda_addsub_pipe
    import rda_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LPS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NLEV = rda_levels(WIDTH);
    localparam int NSEG = rda_nseg(WIDTH, LPS);

    logic adv;

    // Operand stage
    logic             in_vld_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic             c0_reg;

    // Prefix segment stages
    logic [NSEG-1:0]  seg_vld_reg;
    kpg_t [WIDTH:0]   seg_kpg_reg [NSEG];
    logic [WIDTH-1:0] seg_p_reg   [NSEG];

    // Result stage
    logic             out_vld_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    kpg_t [WIDTH:0]   kpg0;
    logic [WIDTH-1:0] p0;
    kpg_t [WIDTH:0]   seg_in  [NSEG];
    kpg_t [WIDTH:0]   seg_out [NSEG];

    kpg_t [WIDTH:0]   y_fin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    // One stall signal freezes every stage, so the output holds until taken.
    assign adv      = !out_vld_reg || out_ready;
    assign in_ready = adv;

    // Position 0 carries the carry-in; position i+1 describes operand bit i.
    always_comb begin
        kpg0    = '0;
        kpg0[0] = c0_reg ? KPG_G : KPG_K;
        for (int i = 0; i < WIDTH; i++) begin
            kpg0[i + 1] = {a_reg[i] & bx_reg[i], a_reg[i] ^ bx_reg[i]};
        end
    end

    assign p0 = a_reg ^ bx_reg;

    genvar gi;
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
        localparam int FIRST = gi * LPS;
        localparam int NL    = ((NLEV - FIRST) < LPS) ? (NLEV - FIRST) : LPS;

        if (gi == 0) begin : g_head
            assign seg_in[gi] = kpg0;
        end else begin : g_tail
            assign seg_in[gi] = seg_kpg_reg[gi - 1];
        end

        rda_prefix_seg #(
            .WIDTH     (WIDTH),
            .FIRST_LVL (FIRST),
            .NLVL      (NL)
        ) u_seg (
            .y_in  (seg_in[gi]),
            .y_out (seg_out[gi])
        );
    end

    // After all levels every position is resolved to G or K relative to position 0.
    always_comb begin
        y_fin = seg_kpg_reg[NSEG - 1];
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = (y_fin[i] == KPG_G);
        end
        sum_next  = seg_p_reg[NSEG - 1] ^ carry;
        cout_next = (y_fin[WIDTH] == KPG_G);
        ovf_next  = carry[WIDTH - 1] ^ cout_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vld_reg  <= 1'b0;
            a_reg       <= '0;
            bx_reg      <= '0;
            c0_reg      <= 1'b0;
            seg_vld_reg <= '0;
            for (int s = 0; s < NSEG; s++) begin
                seg_kpg_reg[s] <= '0;
                seg_p_reg[s]   <= '0;
            end
            out_vld_reg <= 1'b0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (adv) begin
            in_vld_reg     <= in_valid;
            a_reg          <= a;
            bx_reg         <= b ^ {WIDTH{sub}};
            c0_reg         <= sub | cin;
            seg_vld_reg[0] <= in_vld_reg;
            seg_kpg_reg[0] <= seg_out[0];
            seg_p_reg[0]   <= p0;
            for (int s = 1; s < NSEG; s++) begin
                seg_vld_reg[s] <= seg_vld_reg[s - 1];
                seg_kpg_reg[s] <= seg_out[s];
                seg_p_reg[s]   <= seg_p_reg[s - 1];
            end
            out_vld_reg <= seg_vld_reg[NSEG - 1];
            sum_reg     <= sum_next;
            cout_reg    <= cout_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign out_valid = out_vld_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rda_addsub_pipe.sv
// Bench for rda_addsub_pipe: directed corner cases, random streaming against an integer
// reference model, stall/backpressure, mid-stream reset, and an 8-bit LPS=1 instance.
module tb_rda_addsub_pipe;

    localparam int LAT32 = 5;
    localparam int LAT8  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    rda_addsub_pipe #(.WIDTH(32), .LPS(2)) dut32 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    rda_addsub_pipe #(.WIDTH(8), .LPS(1)) dut8 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Integer reference: unsigned result/carry and signed range check on w-bit operands.
    function automatic logic [63:0] ref_model(input int w, input longint unsigned x,
                                              input longint unsigned y, input bit ci, input bit s);
        longint unsigned mask, ures;
        longint one, sx, sy, sres, hi, lo;
        bit co, ov;
        one  = 1;
        mask = (64'd1 << w) - 64'd1;
        sx   = x[w-1] ? longint'(x) - (one << w) : longint'(x);
        sy   = y[w-1] ? longint'(y) - (one << w) : longint'(y);
        if (s) begin
            ures = x - y;
            co   = (x >= y);
            sres = sx - sy;
        end else begin
            ures = x + y + 64'(ci);
            co   = ures[w];
            sres = sx + sy + longint'(ci);
        end
        hi = (one << (w - 1)) - 1;
        lo = -(one << (w - 1));
        ov = (sres > hi) || (sres < lo);
        return (64'(co) << (w + 1)) | (64'(ov) << w) | (ures & mask);
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] res;
    } beat_t;

    beat_t exp_q[$];
    int    cyc = 0;
    int    pops = 0;
    int    first_pop = -1;
    int    last_pop = -1;
    bit    fire_in;

    // One cycle of the 32-bit harness: called and returns at posedge+1.
    task automatic tick();
        beat_t bt;
        @(negedge clk);
        fire_in = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                bt = exp_q.pop_front();
                check("beat", {30'b0, cout, ovf, sum}, bt.res);
                $display("beat a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                         bt.a, bt.b, bt.cin, bt.sub, sum, cout, ovf);
                pops++;
                last_pop = cyc;
                if (first_pop < 0) first_pop = cyc;
            end
        end
        if (fire_in) begin
            bt.a   = a;
            bt.b   = b;
            bt.cin = cin;
            bt.sub = sub;
            bt.res = ref_model(32, 64'(a), 64'(b), cin, sub);
            exp_q.push_back(bt);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic stream(input int ncyc, input int pin, input int pout);
        for (int i = 0; i < ncyc; i++) begin
            a         = pick_operand();
            b         = pick_operand();
            cin       = 1'($urandom_range(1));
            sub       = 1'($urandom_range(1));
            in_valid  = ($urandom_range(99) < pin);
            out_ready = ($urandom_range(99) < pout);
            tick();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic dir32(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic ci, input logic s,
                         input logic [31:0] esum, input logic ecout, input logic eovf);
        int n;
        a = xa; b = xb; cin = ci; sub = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"},  64'(n),    64'(LAT32));
        check({tag, "_sum"},  64'(sum),  64'(esum));
        check({tag, "_cout"}, 64'(cout), 64'(ecout));
        check({tag, "_ovf"},  64'(ovf),  64'(eovf));
        $display("%s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, xa, xb, ci, s, sum, cout, ovf, n);
        @(posedge clk); #1;
    endtask

    task automatic dir8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic ci, input logic s,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
        int n;
        a8 = xa; b8 = xb; cin8 = ci; sub8 = s;
        in_valid8  = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"},  64'(n),     64'(LAT8));
        check({tag, "_sum"},  64'(sum8),  64'(esum));
        check({tag, "_cout"}, 64'(cout8), 64'(ecout));
        check({tag, "_ovf"},  64'(ovf8),  64'(eovf));
        check({tag, "_ref"},  64'({cout8, ovf8, sum8}), ref_model(8, 64'(xa), 64'(xb), ci, s));
        $display("%s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, xa, xb, ci, s, sum8, cout8, ovf8, n);
        @(posedge clk); #1;
    endtask

    logic [33:0] snap;
    int          stale;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corners
        dir32("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
        dir32("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir32("add_cin",   32'h3,         32'h4, 1'b1, 1'b0, 32'h8,         1'b0, 1'b0);
        dir32("sub_neg",   32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir32("sub_cin",   32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir32("sub_ovf",   32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Full-rate streaming: one result per cycle
        pops = 0; first_pop = -1; last_pop = -1;
        stream(1000, 100, 100);
        drain();
        check("stream_count", 64'(pops), 64'd1000);
        check("stream_rate",  64'(last_pop - first_pop), 64'd999);

        // Backpressure with a full pipe
        stream(12, 100, 100);
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b0; sub = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        snap = {cout, ovf, sum};
        check("stall_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid_hold", 64'(out_valid), 64'd1);
            check("stall_frozen", 64'({cout, ovf, sum}), 64'(snap));
        end
        drain();

        // Random valid/ready toggling
        stream(600, 50, 50);
        drain();

        // Reset with a full, stalled pipe
        stream(8, 100, 0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum",   64'(sum),       64'd0);
        check("mid_rst_cout",  64'(cout),      64'd0);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("post_rst_stale", 64'(stale), 64'd0);

        // 8-bit, one level per segment
        dir8("w8_add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        dir8("w8_sub_neg", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        dir8("w8_add_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        dir8("w8_sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
